dmem_ctrl: RTL and testbench

Data-memory access controller placed between the requesters and the byte-addressed data memory (`dmem`). It arbitrates between two requesters: the core load/store unit (`c_`) and the program/debug loader (`l_`). It sequences each access onto the memory's single word-wide port. Sub-word stores become read-modify-write sequences, and sub-word loads are extracted and sign- or zero-extended according to the RISC-V funct3 encoding.

---
 rtl/dmem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: round-robin arbitration between core and loader,
// read-modify-write sub-word stores and RISC-V load extension on one word-wide port.
module dmem_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [2:0]       c_funct3,
    input  logic [WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0] c_wdata,
    output logic             c_ack,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [2:0]       l_funct3,
    input  logic [WIDTH-1:0] l_addr,
    input  logic [WIDTH-1:0] l_wdata,
    output logic             l_ack,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             mem_sel,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ADDR_MAX = WIDTH'(MEM_DEPTH - 4);
    localparam logic [2:0]       F3_W     = 3'b010;

    state_t           state_r, next_s;
    logic             last_loader_r, owner_loader_r, owner_next_s;
    logic             we_r;
    logic [2:0]       f3_r;
    logic [WIDTH-1:0] addr_r, wdata_r, rdata_r;
    logic             err_r, c_ack_r, l_ack_r, sel_r;

    logic             gnt_loader_s, req_any_s, req_we_s, req_err_s;
    logic [2:0]       req_f3_s;
    logic [WIDTH-1:0] req_addr_s, req_wdata_s, load_s, merge_s;

    // Round-robin grant and legality check of the request that would be granted
    always_comb begin
        req_any_s = c_req | l_req;
        if (c_req && l_req) begin
            gnt_loader_s = ~last_loader_r;
        end else begin
            gnt_loader_s = l_req;
        end
        req_we_s    = gnt_loader_s ? l_we     : c_we;
        req_f3_s    = gnt_loader_s ? l_funct3 : c_funct3;
        req_addr_s  = gnt_loader_s ? l_addr   : c_addr;
        req_wdata_s = gnt_loader_s ? l_wdata  : c_wdata;
        // funct3 011/11x are never legal; 1xx (unsigned) is meaningless for stores
        req_err_s   = (req_addr_s > ADDR_MAX) || (req_f3_s == 3'b011) ||
                      (req_f3_s[2:1] == 2'b11) || (req_we_s && req_f3_s[2]);
        if (state_r == IDLE && req_any_s) begin
            owner_next_s = gnt_loader_s;
        end else begin
            owner_next_s = owner_loader_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!req_any_s) begin
                    next_s = IDLE;
                end else if (req_err_s) begin
                    next_s = ACK;
                end else if (req_we_s && req_f3_s == F3_W) begin
                    next_s = WRITE;
                end else begin
                    next_s = READ;
                end
            end
            READ:    next_s = we_r ? WRITE : LOAD;
            LOAD:    next_s = ACK;
            WRITE:   next_s = ACK;
            ACK:     next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Load extension and sub-word merge of the word read back from memory
    always_comb begin
        case (f3_r[1:0])
            2'b00: begin
                load_s  = f3_r[2] ? {{(WIDTH-8){1'b0}}, mem_rdata[7:0]}
                                  : {{(WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
                merge_s = {mem_rdata[WIDTH-1:8], wdata_r[7:0]};
            end
            2'b01: begin
                load_s  = f3_r[2] ? {{(WIDTH-16){1'b0}}, mem_rdata[15:0]}
                                  : {{(WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
                merge_s = {mem_rdata[WIDTH-1:16], wdata_r[15:0]};
            end
            default: begin
                load_s  = mem_rdata;
                merge_s = wdata_r;
            end
        endcase
    end

    // State, request latch and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            last_loader_r  <= 1'b1;
            owner_loader_r <= 1'b0;
            we_r           <= 1'b0;
            f3_r           <= 3'b000;
            addr_r         <= '0;
            wdata_r        <= '0;
            rdata_r        <= '0;
            err_r          <= 1'b0;
            c_ack_r        <= 1'b0;
            l_ack_r        <= 1'b0;
            sel_r          <= 1'b0;
        end else begin
            state_r        <= next_s;
            owner_loader_r <= owner_next_s;
            sel_r          <= (next_s == WRITE);
            c_ack_r        <= (next_s == ACK) && !owner_next_s;
            l_ack_r        <= (next_s == ACK) && owner_next_s;
            case (state_r)
                IDLE: begin
                    if (req_any_s) begin
                        last_loader_r <= gnt_loader_s;
                        we_r          <= req_we_s;
                        f3_r          <= req_f3_s;
                        addr_r        <= req_addr_s;
                        wdata_r       <= req_wdata_s;
                        if (req_err_s) begin
                            err_r   <= 1'b1;
                            rdata_r <= '0;
                        end
                    end
                end
                LOAD: begin
                    rdata_r <= load_s;
                    err_r   <= 1'b0;
                end
                WRITE: begin
                    rdata_r <= '0;
                    err_r   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Merged word is only meaningful while WRITE sees the read-back data
    assign mem_wdata = (state_r == WRITE) ? merge_s : wdata_r;
    assign mem_addr  = addr_r;
    assign mem_sel   = sel_r;
    assign rdata     = rdata_r;
    assign err       = err_r;
    assign c_ack     = c_ack_r;
    assign l_ack     = l_ack_r;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array memory, byte-level reference model,
// directed scenarios plus randomized single-port traffic.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, l_req, l_we;
    logic [2:0]  c_funct3, l_funct3;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_ack, l_ack, err, mem_sel;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [7:0]  dmem    [0:1023];
    logic [7:0]  ref_mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_ack(c_ack),
        .l_req(l_req), .l_we(l_we), .l_funct3(l_funct3), .l_addr(l_addr),
        .l_wdata(l_wdata), .l_ack(l_ack),
        .rdata(rdata), .err(err), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte-addressed memory with registered little-endian word read
    always @(posedge clk) begin
        if (mem_addr <= 32'd1020) begin
            mem_rdata <= {dmem[mem_addr[9:0] + 10'd3], dmem[mem_addr[9:0] + 10'd2],
                          dmem[mem_addr[9:0] + 10'd1], dmem[mem_addr[9:0]]};
            if (mem_sel) begin
                for (int i = 0; i < 4; i++) dmem[mem_addr[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];
            end
        end else begin
            mem_rdata <= 32'd0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: result of one access computed byte by byte; stores update ref_mem
    function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output bit e);
        int unsigned w;
        int          nb;
        e  = (a > 32'd1020) || (f3 == 3'b011) || (f3 >= 3'b110) || (we && f3 >= 3'b100);
        rd = 32'd0;
        nb = 1 << (f3 % 4);
        if (!e && we) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
        end else if (!e) begin
            w = 0;
            for (int i = 0; i < nb; i++) w += int'(ref_mem[a + i]) << (8 * i);
            if (f3 < 3'b100 && nb < 4 && w >= (32'd1 << (8 * nb - 1))) w = w - (32'd1 << (8 * nb));
            rd = w;
        end
    endfunction

    task automatic drive(input bit ld, input bit req, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (ld) begin
            l_req = req; l_we = we; l_funct3 = f3; l_addr = a; l_wdata = wd;
        end else begin
            c_req = req; c_we = we; c_funct3 = f3; c_addr = a; c_wdata = wd;
        end
    endtask

    task automatic access(input bit ld, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_lat, lat, sels, sel_cyc;
        model(we, f3, a, wd, exp_rd, exp_err);
        exp_lat = exp_err ? 1 : ((we && f3 == 3'b010) ? 2 : 3);
        @(posedge clk); #1;
        drive(ld, 1'b1, we, f3, a, wd);
        lat = -1; sels = 0; sel_cyc = -1;
        for (int cyc = 0; cyc < 12 && lat < 0; cyc++) begin
            @(negedge clk);
            if (mem_sel) begin sels++; sel_cyc = cyc; end
            if (cyc == 1) drive(ld, 1'b1, 1'($urandom), 3'($urandom), $urandom, $urandom);
            if ((ld ? l_ack : c_ack) == 1'b1) begin
                lat = cyc;
                check_eq("rdata", rdata, exp_rd);
                check_eq("err", 32'(err), 32'(exp_err));
                check_eq("other_ack", 32'(ld ? c_ack : l_ack), 32'd0);
            end else if (c_ack || l_ack) begin
                check_eq("wrong_port_ack", 32'(c_ack || l_ack), 32'd0);
            end
        end
        @(posedge clk); #1;
        drive(ld, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("sel_count", 32'(sels), (exp_err || !we) ? 32'd0 : 32'd1);
        if (!exp_err && we) check_eq("sel_cycle", 32'(sel_cyc), 32'(exp_lat - 1));
    endtask

    task automatic tie(input bit exp_loader_first);
        logic [31:0] exp_c, exp_l;
        bit          e;
        int          c_lat, l_lat, both;
        model(1'b0, 3'b010, 32'h10, 32'd0, exp_c, e);
        model(1'b0, 3'b010, 32'h20, 32'd0, exp_l, e);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        c_lat = -1; l_lat = -1; both = 0;
        for (int cyc = 0; cyc < 20 && (c_lat < 0 || l_lat < 0); cyc++) begin
            @(negedge clk);
            if (c_ack && l_ack) both++;
            if (c_ack) begin c_lat = cyc; check_eq("tie_c_rdata", rdata, exp_c); end
            if (l_ack) begin l_lat = cyc; check_eq("tie_l_rdata", rdata, exp_l); end
            @(posedge clk); #1;
            if (c_lat >= 0) c_req = 1'b0;
            if (l_lat >= 0) l_req = 1'b0;
        end
        c_req = 1'b0; l_req = 1'b0;
        check_eq("tie_overlap", 32'(both), 32'd0);
        check_eq("tie_c_lat", 32'(c_lat), exp_loader_first ? 32'd7 : 32'd3);
        check_eq("tie_l_lat", 32'(l_lat), exp_loader_first ? 32'd3 : 32'd7);
    endtask

    initial begin
        int sels, acks, diffs;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", rdata | mem_addr | mem_wdata | {28'd0, c_ack, l_ack, err, mem_sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Arbitration: core wins first tie, then the port not granted last
        tie(1'b0);
        tie(1'b0);
        access(1'b0, 1'b0, 3'b010, 32'h40, 32'd0);
        tie(1'b1);

        // Word and sub-word stores, loads with extension
        access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0);
        access(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA);
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0);
        access(1'b0, 1'b0, 3'b000, 32'h11, 32'd0);
        access(1'b0, 1'b0, 3'b100, 32'h11, 32'd0);
        access(1'b0, 1'b0, 3'b001, 32'h12, 32'd0);
        access(1'b1, 1'b1, 3'b001, 32'h13, 32'h00001234);
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0);
        access(1'b0, 1'b0, 3'b010, 32'h14, 32'd0);
        access(1'b1, 1'b0, 3'b101, 32'h13, 32'd0);

        // Range and encoding errors, top legal address
        access(1'b0, 1'b0, 3'b010, 32'd1021, 32'd0);
        access(1'b0, 1'b0, 3'b010, 32'd1020, 32'd0);
        access(1'b0, 1'b0, 3'b011, 32'h40, 32'd0);
        access(1'b1, 1'b1, 3'b100, 32'h10, 32'h11223344);
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'd0);

        // Reset during READ of a byte store
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 3'b000, 32'h30, 32'h55);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        sels = 0; acks = 0;
        @(negedge clk);
        sels += 32'(mem_sel); acks += 32'(c_ack | l_ack);
        @(negedge clk);
        check_eq("midop_reset_outputs", rdata | mem_addr | mem_wdata | {28'd0, c_ack, l_ack, err, mem_sel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sels += 32'(mem_sel); acks += 32'(c_ack | l_ack);
        end
        check_eq("midop_no_sel", 32'(sels), 32'd0);
        check_eq("midop_no_ack", 32'(acks), 32'd0);
        access(1'b0, 1'b0, 3'b010, 32'h30, 32'd0);
        access(1'b0, 1'b1, 3'b000, 32'h30, 32'h55);
        access(1'b0, 1'b0, 3'b100, 32'h30, 32'd0);

        // Randomized single-port traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 19))
                0:       a = $urandom;
                1, 2, 3: a = 32'($urandom_range(1016, 1023));
                default: a = 32'($urandom_range(0, 63));
            endcase
            access(1'($urandom), 1'($urandom), 3'($urandom), a, $urandom);
        end

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) diffs++;
        check_eq("mem_final", 32'(diffs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
